// File: rtl/aes_pkg.sv
// Shared types and constants for the AES S-box scheduling block.
package aes_pkg;
  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sbox_sched_e;

  function automatic bit lanes_ok(input int lanes);
    return (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction
endpackage

// File: rtl/aes_sbox_sched_if.sv
// State stream, SubWord port and status bundle between the AES core and the S-box scheduler.
interface aes_sbox_sched_if;
  import aes_pkg::*;

  logic   st_valid;
  logic   st_ready;
  state_t st_in;
  logic   st_out_valid;
  logic   st_out_ready;
  state_t st_out;
  logic   kw_req;
  word_t  kw_in;
  logic   kw_ack;
  word_t  kw_out;
  logic   busy;

  modport master (
    output st_valid, st_in, st_out_ready, kw_req, kw_in,
    input  st_ready, st_out_valid, st_out, kw_ack, kw_out, busy
  );
  modport slave (
    input  st_valid, st_in, st_out_ready, kw_req, kw_in,
    output st_ready, st_out_valid, st_out, kw_ack, kw_out, busy
  );
endinterface

// File: rtl/S_box.sv
// AES forward S-box, pure combinational table lookup.
module S_box (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];
endmodule

// File: rtl/aes_sbox_lane_bank.sv
// Bank of LANES independent S-boxes; lane j uses bits [8j +: 8] of the flat buses.
module aes_sbox_lane_bank #(
  parameter int LANES = 4
) (
  input  logic [LANES*8-1:0] lane_in,
  output logic [LANES*8-1:0] lane_out
);
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    S_box u_sbox (
      .a (lane_in[j*8 +: 8]),
      .y (lane_out[j*8 +: 8])
    );
  end
endmodule

// File: rtl/aes_sbox_sched.sv
// Time-shared SubBytes engine: 16/LANES beats per state, SubWord requests preempt a data beat.
// Key requests are granted at most every other cycle so the data path always makes progress.
module aes_sbox_sched
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  aes_sbox_sched_if.slave  io
);
  localparam int B  = 16 / LANES;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("aes_sbox_sched: LANES must be 4, 8 or 16");
  end

  sbox_sched_e          state, next;
  state_t               ws, ws_upd;
  logic [BW-1:0]        beat;
  logic                 kw_fl;
  word_t                kw_q;
  logic [LANES*8-1:0]   lane_in, lane_out;
  logic                 kg, accept, last_beat;
  word_t                kw_sub;

  assign kg        = io.kw_req & ~kw_fl;
  assign accept    = io.st_valid & io.st_ready;
  assign last_beat = (beat == BW'(B - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = RUN;
      RUN:     if (!kg && last_beat) next = DONE;
      DONE:    if (io.st_out_ready) next = accept ? RUN : IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    io.st_ready     = ~rst & ((state == IDLE) | ((state == DONE) & io.st_out_ready));
    io.st_out_valid = (state == DONE);
    io.busy         = (state == RUN) | (state == DONE);
  end

  // A key grant owns lanes 0..3 for the cycle; the data beat simply waits.
  always_comb begin
    lane_in = '0;
    for (int j = 0; j < LANES; j++)
      lane_in[j*8 +: 8] = ws[127 - 8*(int'(beat)*LANES + j) -: 8];
    if (kg)
      lane_in[31:0] = {io.kw_in[7:0], io.kw_in[15:8], io.kw_in[23:16], io.kw_in[31:24]};
  end

  aes_sbox_lane_bank #(.LANES(LANES)) u_bank (
    .lane_in  (lane_in),
    .lane_out (lane_out)
  );

  assign kw_sub = {lane_out[7:0], lane_out[15:8], lane_out[23:16], lane_out[31:24]};

  always_comb begin
    ws_upd = ws;
    for (int j = 0; j < LANES; j++)
      ws_upd[127 - 8*(int'(beat)*LANES + j) -: 8] = lane_out[j*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws    <= '0;
      beat  <= '0;
      kw_fl <= 1'b0;
      kw_q  <= '0;
    end else begin
      kw_fl <= kg;
      if (kg) kw_q <= kw_sub;
      if (accept) begin
        ws   <= io.st_in;
        beat <= '0;
      end else if (state == RUN && !kg) begin
        ws   <= ws_upd;
        beat <= beat + 1'b1;
      end
    end
  end

  assign io.st_out = ws;
  assign io.kw_ack = kw_fl;
  assign io.kw_out = kw_q;
endmodule
